// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: WIDTH-generic EX-stage ALU with a multi-cycle multiply/divide
// engine and architectural HI/LO registers.
//
// Single-cycle ops (AND/OR/ADD/SUB/SLT/SLL, MFHI/MFLO) drive dataOut
// combinationally. MULTU/DIVU iterate one bit per cycle. busy is high for
// WIDTH cycles after the start edge. The cycle after that is DONE: done pulses
// and hi/lo show the result.
//
// Optional build macro: ALU_SIGNED_MULDIV_EN adds MULT (1100) and DIV (1101).
// These run the same engine on operand magnitudes and fix the result signs on
// the way into HI/LO, so they have the same latency as the unsigned ops.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high
//   dataA    operand A (rs); multiplicand / dividend
//   dataB    operand B (rt); shift source; multiplier / divisor
//   control  operation select
//   shamt    shift amount for SLL
//   start    launch a mul/div when control selects one
//   dataOut  combinational result
//   busy     mul/div engine iterating (registered)
//   done     one-cycle pulse when HI/LO are updated (registered)
//   hi, lo   architectural HI/LO registers

module alu_muldiv_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [3:0]         control,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               start,
    output logic [WIDTH-1:0]   dataOut,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    localparam int unsigned      DW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [DW-1:0]      acc_q;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;     // mul: multiplicand; div: divisor
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sel_mul;
    logic               sel_div;
    logic               launch;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [DW-1:0]      mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [DW-1:0]      div_next;
    logic [DW-1:0]      step_next;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

`ifdef ALU_SIGNED_MULDIV_EN
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic               neg_lo_q;  // negate quotient, or the whole product for MULT
    logic               neg_hi_q;  // negate remainder
    logic [DW-1:0]      neg_prod;
`endif

    // Opcode decode for the mul/div engine
    always_comb begin
        sel_mul = 1'b0;
        sel_div = 1'b0;
`ifdef ALU_SIGNED_MULDIV_EN
        op_signed = 1'b0;
`endif
        case (control)
            OP_MULTU: sel_mul = 1'b1;
            OP_DIVU:  sel_div = 1'b1;
`ifdef ALU_SIGNED_MULDIV_EN
            OP_MULT: begin
                sel_mul   = 1'b1;
                op_signed = 1'b1;
            end
            OP_DIV: begin
                sel_div   = 1'b1;
                op_signed = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // A start is accepted only in IDLE or DONE (back-to-back issue)
    assign launch = start && (sel_mul || sel_div)
                    && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Operand magnitudes fed to the unsigned engine
    always_comb begin
        a_mag = dataA;
        b_mag = dataB;
`ifdef ALU_SIGNED_MULDIV_EN
        a_neg = op_signed & dataA[WIDTH-1];
        b_neg = op_signed & dataB[WIDTH-1];
        if (a_neg) begin
            a_mag = -dataA;
        end
        if (b_neg) begin
            b_mag = -dataB;
        end
`endif
    end

    // One shift-add step (right shift) and one restoring-divide step (left shift)
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_diff[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        step_next = (state_q == S_MUL) ? mul_next : div_next;
    end

    // Final HI/LO values taken from the last step, with sign fix-up when enabled
    always_comb begin
        res_hi = step_next[DW-1:WIDTH];
        res_lo = step_next[WIDTH-1:0];
`ifdef ALU_SIGNED_MULDIV_EN
        neg_prod = -step_next;
        if (state_q == S_MUL) begin
            if (neg_lo_q) begin
                res_hi = neg_prod[DW-1:WIDTH];
                res_lo = neg_prod[WIDTH-1:0];
            end
        end else begin
            if (neg_lo_q) begin
                res_lo = -step_next[WIDTH-1:0];
            end
            if (neg_hi_q) begin
                res_hi = -step_next[DW-1:WIDTH];
            end
        end
`endif
    end

    // Engine FSM; hi/lo are written only on the transition into DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef ALU_SIGNED_MULDIV_EN
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state_q <= sel_mul ? S_MUL : S_DIV;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        opb_q   <= sel_mul ? a_mag : b_mag;
                        acc_q   <= sel_mul ? {{WIDTH{1'b0}}, b_mag}
                                           : {{WIDTH{1'b0}}, a_mag};
`ifdef ALU_SIGNED_MULDIV_EN
                        // Divide by zero keeps the all-ones quotient unsigned
                        neg_lo_q <= sel_mul ? (a_neg ^ b_neg)
                                            : ((a_neg ^ b_neg) && (dataB != '0));
                        neg_hi_q <= sel_div & a_neg;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL, S_DIV: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Combinational result path, independent of the engine state
    always_comb begin
        dataOut = '0;
        case (control)
            OP_AND:  dataOut = dataA & dataB;
            OP_OR:   dataOut = dataA | dataB;
            OP_ADD:  dataOut = dataA + dataB;
            OP_SUB:  dataOut = dataA - dataB;
            OP_SLT:  dataOut = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            OP_SLL:  dataOut = dataB << shamt;
            OP_MFHI: dataOut = hi_q;
            OP_MFLO: dataOut = lo_q;
            default: dataOut = '0;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq (WIDTH=32). Stimulus pushes expected results
// into queues; a negedge monitor pops and compares whenever the DUT pulses done
// or the stimulus marks dataOut as ready to check.
// Latency counted in edges: start sampled at edge N -> busy seen after edges
// N..N+31, done/hi/lo seen after edge N+32 (the 33rd cycle).

module tb_alu_muldiv_seq;

    localparam int unsigned W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic [3:0]   control;
    logic [4:0]   shamt;
    logic         start;
    logic [W-1:0] dataOut;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    typedef struct {
        string        name;
        logic [W-1:0] val;
    } comb_t;

    exp_t        done_exp[$];
    comb_t       comb_exp[$];
    exp_t        mon_e;
    comb_t       mon_c;
    bit          comb_vld = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned n0;
    int unsigned n1;

    alu_muldiv_seq #(.WIDTH(32), .SHAMT_W(5), .CNT_W(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .dataA   (dataA),
        .dataB   (dataB),
        .control (control),
        .shamt   (shamt),
        .start   (start),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare dataOut when flagged and every done pulse against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (comb_vld) begin
                if (comb_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL comb_underflow: dataOut=0x%0h with no expected value queued", dataOut);
                end else begin
                    mon_c = comb_exp.pop_front();
                    chk(mon_c.name, dataOut, mon_c.val);
                end
            end
            if (done) begin
                if (done_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: cycle %0d hi=0x%0h lo=0x%0h, none expected", cyc, hi, lo);
                end else begin
                    mon_e = done_exp.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("hi", hi, mon_e.hi);
                    chk("lo", lo, mon_e.lo);
                end
            end
        end
    end

    task automatic comb(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic [W-1:0] exp, input string name);
        comb_t e;
        @(posedge clk);
        #1;
        control = c;
        dataA   = a;
        dataB   = b;
        shamt   = sh;
        start   = 1'b0;
        e.name  = name;
        e.val   = exp;
        comb_exp.push_back(e);
        comb_vld = 1'b1;
        @(posedge clk);
        #1;
        comb_vld = 1'b0;
    endtask

    // Drive a start; the next posedge is edge N, expected done after edge N+W
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_done, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        control = c;
        dataA   = a;
        dataB   = b;
        start   = 1'b1;
        @(posedge clk);
        #1;
        if (expect_done) begin
            e.cyc = cyc + W;
            e.hi  = eh;
            e.lo  = el;
            done_exp.push_back(e);
        end
        start = 1'b0;
    endtask

    task automatic at_neg(input int unsigned t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (done_exp.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_exp.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d results still pending, expected 0", done_exp.size());
            done_exp.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        control = OP_AND;
        dataA   = '0;
        dataB   = '0;
        shamt   = '0;
        start   = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops
        comb(OP_ADD,   32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, "add_wrap");
        comb(OP_SUB,   32'd5,        32'd7,        5'd0,  32'hFFFFFFFE, "sub_neg");
        comb(OP_SLT,   32'h80000000, 32'h00000001, 5'd0,  32'd1,        "slt_minneg");
        comb(OP_SLT,   32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'd0,        "slt_max_vs_m1");
        comb(OP_SLT,   32'h7FFFFFFF, 32'h80000000, 5'd0,  32'd0,        "slt_ovf");
        comb(OP_SLL,   32'h0,        32'h00000001, 5'd31, 32'h80000000, "sll_31");
        comb(OP_AND,   32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, "and");
        comb(OP_OR,    32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, "or");
        comb(OP_MULTU, 32'd3,        32'd4,        5'd0,  32'd0,        "multu_out0");
        comb(4'b1111,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'd0,        "undef_1111");

        // DIVU 100/7
        @(negedge clk); #2;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
        drain();

        // MULTU max*max with busy window, stale MFHI/MFLO and a start while busy
        @(negedge clk); #2;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        n0 = cyc;
        at_neg(n0);
        chk("busy_first", busy, 1);
        #2;
        control = OP_DIVU;
        dataA   = 32'd1;
        dataB   = 32'd1;
        start   = 1'b1;
        at_neg(n0 + 2);
        #2;
        start   = 1'b0;
        control = OP_MFHI;
        mon_c.name = "mfhi_busy";
        mon_c.val  = 32'd2;
        comb_exp.push_back(mon_c);
        comb_vld = 1'b1;
        at_neg(n0 + 3);
        #2;
        control = OP_MFLO;
        mon_c.name = "mflo_busy";
        mon_c.val  = 32'd14;
        comb_exp.push_back(mon_c);
        at_neg(n0 + 4);
        #2;
        comb_vld = 1'b0;
        at_neg(n0 + W - 1);
        chk("busy_last", busy, 1);
        at_neg(n0 + W);
        chk("busy_drop", busy, 0);
        #2;
        // Back-to-back: start sampled in the DONE cycle
        issue(OP_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
        n1 = cyc;
        at_neg(n1 + 5);
        #2;
        control = OP_MULTU;
        dataA   = 32'd7;
        dataB   = 32'd7;
        start   = 1'b1;
        at_neg(n1 + 6);
        #2;
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Divide by zero
        #2;
        issue(OP_DIVU, 32'h00001234, 32'd0, 1'b1, 32'h00001234, 32'hFFFFFFFF);
        drain();

        // Asynchronous reset mid-divide
        @(negedge clk); #2;
        issue(OP_DIVU, 32'h0000FFFF, 32'd3, 1'b0, 32'd0, 32'd0);
        n0 = cyc;
        at_neg(n0 + 10);
        chk("busy_pre_abort", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1, 32'd0, 32'd3);
        drain();
        comb(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd3, "mflo_after");
        comb(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, "mfhi_after");

`ifdef ALU_SIGNED_MULDIV_EN
        @(negedge clk); #2;
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        drain();
        @(negedge clk); #2;
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        drain();
        @(negedge clk); #2;
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000);
        drain();
        @(negedge clk); #2;
        issue(OP_DIV, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF);
        drain();
`else
        comb(OP_MULT, 32'd3, 32'd5, 5'd0, 32'd0, "undef_1100");
        @(negedge clk); #2;
        issue(OP_MULT, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
        n0 = cyc;
        at_neg(n0);
        chk("undef_no_busy", busy, 0);
        #2;
        issue(OP_DIV, 32'd8, 32'd2, 1'b0, 32'd0, 32'd0);
        n0 = cyc;
        at_neg(n0);
        chk("undef_no_busy2", busy, 0);
`endif

        repeat (40) @(negedge clk);
        chk("pending_results", 64'(done_exp.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
